rr_onehot_arbiter: RTL and testbench

- Round-robin arbiter that shares one resource among 8 requesters.
- Picks one winner, registers the 3-bit winner index, and drives the one-hot grant vector through the team's 3-to-8 decoder.
- Grants are break-before-make: every owner change has exactly one dead cycle.
- An optional hold timeout stops any single requester from monopolising the resource.

---
 rtl/arb_pkg.sv | 40 ++++
 rtl/rr_onehot_arbiter_dec.sv | 17 +
 rtl/rr_onehot_arbiter.sv | 119 +++++++++++
 tb/tb_rr_onehot_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// ----------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the round-robin one-hot arbiter:
//   N_REQ       - number of requesters (fixed at 8)
//   IDX_W       - width of a requester index (3 bits)
//   arb_state_t - arbiter FSM states (IDLE, BUSY)
//   rr_pick()   - rotating priority search: returns the first requester
//                 with its bit set, scanning upward from ptr and wrapping
//                 from 7 back to 0.
// ----------------------------------------------------------------------------
package arb_pkg;

   localparam int N_REQ = 8;
   localparam int IDX_W = 3;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   // The index arithmetic is IDX_W bits wide, so ptr + k wraps modulo 8 on
   // its own. The first hit wins; the found flag stops later hits from
   // overriding it. Returns ptr when nothing requests; callers only use the
   // result when at least one request is present.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                input logic [IDX_W-1:0] ptr);
      logic [IDX_W-1:0] idx;
      logic             found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = ptr + IDX_W'(k);
         if (!found && req[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

endpackage

// File: rtl/rr_onehot_arbiter_dec.sv
// ----------------------------------------------------------------------------
// rr_onehot_arbiter_dec
// 3-bit index to 8-bit one-hot decoder.
// Ports:
//   idx    in  3  binary index
//   onehot out 8  one-hot vector with bit idx set
// ----------------------------------------------------------------------------
module rr_onehot_arbiter_dec
   import arb_pkg::*;
(
   input  logic [IDX_W-1:0] idx,
   output logic [N_REQ-1:0] onehot
);

   assign onehot = N_REQ'(1) << idx;

endmodule

// File: rtl/rr_onehot_arbiter.sv
// ----------------------------------------------------------------------------
// rr_onehot_arbiter
// Round-robin arbiter sharing one resource among 8 requesters. The winner
// index is registered, and the one-hot grant is a decode of that registered
// index gated by the registered valid flag, so there is no combinational
// path from req to gnt. Every change of owner passes through one IDLE cycle
// with gnt=0. An optional hold timeout (MAX_HOLD cycles, 0 = disabled)
// revokes a grant that has been held too long.
// Ports:
//   clk       in  1  system clock, rising edge
//   rst       in  1  synchronous active-high reset
//   req       in  8  request vector; req[i] held high for the whole tenure
//   gnt       out 8  one-hot grant, zero when there is no owner
//   gnt_idx   out 3  index of the current or last owner
//   gnt_valid out 1  high while a grant is active
//   timeout   out 1  one-cycle pulse in the dead cycle after a forced revoke
// ----------------------------------------------------------------------------
module rr_onehot_arbiter
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_valid,
   output logic             timeout
);

   // At least one bit, even when the timeout is disabled.
   localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   // Counter value in the last permitted grant cycle of a tenure.
   localparam logic [HOLD_W-1:0] HOLD_LAST =
      (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);
   localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

   arb_state_t        state, state_nx;
   logic [IDX_W-1:0]  ptr, ptr_nx;
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_nx;
   logic [IDX_W-1:0]  gnt_idx_nx;
   logic              gnt_valid_nx;
   logic              timeout_nx;
   logic              owner_req;
   logic              hold_expired;
   logic [N_REQ-1:0]  dec_out;

   assign owner_req    = req[gnt_idx];
   assign hold_expired = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);

   // State register plus all registered outputs. Reset wins over everything,
   // including an active grant, so gnt drops on the reset edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         hold_cnt  <= '0;
         gnt_idx   <= '0;
         gnt_valid <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_nx;
         ptr       <= ptr_nx;
         hold_cnt  <= hold_cnt_nx;
         gnt_idx   <= gnt_idx_nx;
         gnt_valid <= gnt_valid_nx;
         timeout   <= timeout_nx;
      end
   end

   // Next-state logic. IDLE grants to the rotating-priority winner; BUSY
   // watches only the owner's request line and the hold counter. Leaving
   // BUSY always goes through IDLE, which produces the dead cycle, and moves
   // the priority pointer just past the departing owner.
   always_comb begin
      state_nx     = state;
      ptr_nx       = ptr;
      hold_cnt_nx  = hold_cnt;
      gnt_idx_nx   = gnt_idx;
      gnt_valid_nx = 1'b0;
      timeout_nx   = 1'b0;
      case (state)
         IDLE: begin
            if (|req) begin
               state_nx     = BUSY;
               gnt_idx_nx   = rr_pick(req, ptr);
               gnt_valid_nx = 1'b1;
               hold_cnt_nx  = '0;
            end
         end
         BUSY: begin
            if (!owner_req || hold_expired) begin
               state_nx   = IDLE;
               ptr_nx     = gnt_idx + IDX_W'(1);
               // A voluntary release takes priority over a simultaneous expiry.
               timeout_nx = owner_req;
            end else begin
               gnt_valid_nx = 1'b1;
               if (hold_cnt != HOLD_SAT) begin
                  hold_cnt_nx = hold_cnt + HOLD_W'(1);
               end
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   rr_onehot_arbiter_dec u_dec (
      .idx    (gnt_idx),
      .onehot (dec_out)
   );

   assign gnt = dec_out & {N_REQ{gnt_valid}};

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// ----------------------------------------------------------------------------
// tb_rr_onehot_arbiter
// Drives three arbiters (MAX_HOLD = 16, 4, 0) from the same clock, reset and
// request vector, and compares every output of each against a behavioural
// model of owner / tenure length / scan start position. Directed phases
// follow the reset, single-requester, fairness, wrap-around, timeout and
// reset-mid-grant scenarios, followed by a randomized run.
// ----------------------------------------------------------------------------
module tb_rr_onehot_arbiter;

   localparam int NI = 3;
   localparam int MAXH [NI] = '{16, 4, 0};

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic [7:0] gnt_o   [NI];
   logic [2:0] idx_o   [NI];
   logic       valid_o [NI];
   logic       to_o    [NI];

   int total;
   int bad;

   // Behavioural model state per instance: owner is -1 when nobody holds
   // the resource; held counts grant cycles in the current tenure.
   int m_owner [NI];
   int m_last  [NI];
   int m_start [NI];
   int m_held  [NI];
   bit m_to    [NI];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   rr_onehot_arbiter #(.MAX_HOLD(16)) dut16 (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt_o[0]), .gnt_idx(idx_o[0]),
      .gnt_valid(valid_o[0]), .timeout(to_o[0]));

   rr_onehot_arbiter #(.MAX_HOLD(4)) dut4 (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt_o[1]), .gnt_idx(idx_o[1]),
      .gnt_valid(valid_o[1]), .timeout(to_o[1]));

   rr_onehot_arbiter #(.MAX_HOLD(0)) dut0 (
      .clk(clk), .rst(rst), .req(req), .gnt(gnt_o[2]), .gnt_idx(idx_o[2]),
      .gnt_valid(valid_o[2]), .timeout(to_o[2]));

   // The single comparison point: counts and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int pickWinner(input logic [7:0] r, input int start);
      for (int k = 0; k < 8; k++) begin
         if (r[(start + k) % 8]) return (start + k) % 8;
      end
      return -1;
   endfunction

   // One clock edge of the reference behaviour for each instance.
   task automatic modelStep();
      for (int i = 0; i < NI; i++) begin
         if (rst) begin
            m_owner[i] = -1; m_last[i] = 0; m_start[i] = 0;
            m_held[i]  = 0;  m_to[i]   = 1'b0;
         end else if (m_owner[i] < 0) begin
            m_to[i] = 1'b0;
            if (req != 8'h00) begin
               m_owner[i] = pickWinner(req, m_start[i]);
               m_last[i]  = m_owner[i];
               m_held[i]  = 1;
            end
         end else if (!req[m_owner[i]]) begin
            m_start[i] = (m_owner[i] + 1) % 8;
            m_owner[i] = -1;
            m_to[i]    = 1'b0;
         end else if (MAXH[i] != 0 && m_held[i] == MAXH[i]) begin
            m_start[i] = (m_owner[i] + 1) % 8;
            m_owner[i] = -1;
            m_to[i]    = 1'b1;
         end else begin
            m_held[i]++;
            m_to[i] = 1'b0;
         end
      end
   endtask

   task automatic compareAll(input string tag);
      logic [12:0] exp;
      logic [12:0] obs;
      for (int i = 0; i < NI; i++) begin
         exp = {(m_owner[i] >= 0) ? (8'h01 << m_owner[i]) : 8'h00,
                3'(m_last[i]), (m_owner[i] >= 0), m_to[i]};
         obs = {gnt_o[i], idx_o[i], valid_o[i], to_o[i]};
         checkOutput($sformatf("%s_h%0d", tag, MAXH[i]), 32'(obs), 32'(exp));
      end
   endtask

   // Applies inputs away from the edge, advances the model on the edge and
   // samples the DUTs 1 time unit later.
   task automatic applyStimulus(input logic r_rst, input logic [7:0] r_req,
                                input string tag);
      rst = r_rst;
      req = r_req;
      @(posedge clk);
      modelStep();
      #1;
      compareAll(tag);
   endtask

   initial begin
      logic [7:0] r;
      int         grants;
      int         to_cnt [NI];
      bit         prev_valid;

      total = 0;
      bad   = 0;
      rst   = 1'b1;
      req   = 8'h00;
      for (int i = 0; i < NI; i++) begin
         m_owner[i] = -1; m_last[i] = 0; m_start[i] = 0;
         m_held[i]  = 0;  m_to[i]   = 1'b0;
      end

      // Reset under full load, then the first grant goes to 0.
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b1, 8'hFF, "t1_rst");
         checkOutput("t1_rst_gnt", 32'(gnt_o[0]), 32'h00);
      end
      applyStimulus(1'b0, 8'hFF, "t1_first");
      checkOutput("t1_first_gnt", 32'(gnt_o[0]), 32'h01);
      applyStimulus(1'b0, 8'h00, "t1_rel");

      // Single requester 2, then wrap-around from ptr=6.
      applyStimulus(1'b1, 8'h00, "t2_rst");
      applyStimulus(1'b0, 8'h04, "t2_grant");
      checkOutput("t2_gnt", 32'(gnt_o[0]), 32'h04);
      checkOutput("t2_idx", 32'(idx_o[0]), 32'd2);
      for (int c = 0; c < 4; c++) applyStimulus(1'b0, 8'h04, "t2_hold");
      applyStimulus(1'b0, 8'h00, "t2_rel");
      checkOutput("t2_rel_valid", 32'(valid_o[0]), 32'd0);
      applyStimulus(1'b0, 8'h20, "t4_g5");
      checkOutput("t4_g5_idx", 32'(idx_o[0]), 32'd5);
      applyStimulus(1'b0, 8'h00, "t4_rel5");
      applyStimulus(1'b0, 8'h21, "t4_g0");
      checkOutput("t4_g0_gnt", 32'(gnt_o[0]), 32'h01);
      applyStimulus(1'b0, 8'h20, "t4_rel0");
      applyStimulus(1'b0, 8'h20, "t4_g5b");
      checkOutput("t4_g5b_gnt", 32'(gnt_o[0]), 32'h20);

      // Fairness: each owner drops its bit after two grant cycles.
      applyStimulus(1'b1, 8'h00, "t3_rst");
      grants     = 0;
      prev_valid = 1'b0;
      for (int c = 0; c < 60 && grants < 9; c++) begin
         r = 8'hFF;
         if (m_owner[0] >= 0 && m_held[0] == 2) r[m_owner[0]] = 1'b0;
         applyStimulus(1'b0, r, "t3");
         if (valid_o[0] && !prev_valid) begin
            checkOutput("t3_order", 32'(idx_o[0]), 32'(grants % 8));
            grants++;
         end
         prev_valid = valid_o[0];
      end
      checkOutput("t3_count", 32'(grants), 32'd9);

      // Timeout: requester 3 holds forever.
      applyStimulus(1'b1, 8'h00, "t5_rst");
      for (int i = 0; i < NI; i++) to_cnt[i] = 0;
      for (int c = 0; c < 24; c++) begin
         applyStimulus(1'b0, 8'h08, "t5");
         for (int i = 0; i < NI; i++) to_cnt[i] += int'(to_o[i]);
      end
      checkOutput("t5_to_h16", 32'(to_cnt[0]), 32'd1);
      checkOutput("t5_to_h4",  32'(to_cnt[1]), 32'd4);
      checkOutput("t5_to_h0",  32'(to_cnt[2]), 32'd0);
      checkOutput("t5_h0_gnt", 32'(gnt_o[2]), 32'h08);

      // Reset in the middle of a grant to requester 6.
      applyStimulus(1'b1, 8'h00, "t6_rst0");
      for (int c = 0; c < 3; c++) applyStimulus(1'b0, 8'h40, "t6_own");
      applyStimulus(1'b1, 8'h40, "t6_rst");
      checkOutput("t6_rst_gnt", 32'(gnt_o[0]), 32'h00);
      applyStimulus(1'b0, 8'h40, "t6_regrant");
      checkOutput("t6_regrant_gnt", 32'(gnt_o[0]), 32'h40);

      // Randomized traffic with occasional resets.
      r = 8'h00;
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(3) == 0) r = 8'($urandom) & 8'($urandom);
         applyStimulus(($urandom_range(63) == 0), r, "rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
